// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, latency and skid-depth constants for the FIFO read-side stream engine
package fifo_pkg;
   localparam int DEFAULT_WIDTH   = 32;
   localparam int FIFO_RD_LATENCY = 1;
   localparam int SKID_DEPTH      = 2;

   typedef logic [1:0] count_t;

   function automatic int beat_width(input int pkt_len);
      return (pkt_len > 1) ? $clog2(pkt_len) : 1;
   endfunction
endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - two-entry output buffer; slot0 is the head and drives the stream data
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             pop,
   output count_t           count
);
   logic [WIDTH-1:0] slot0;
   logic [WIDTH-1:0] slot1;
   count_t           after_pop;

   assign rd_valid  = (count != 2'd0);
   assign pop       = rd_valid & rd_ready;
   assign after_pop = count - count_t'(pop);
   assign rd_data   = slot0;

   // The capture is ordered after the shift so a word landing in an emptied buffer wins slot0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         count <= after_pop + count_t'(wr_valid);
         if (pop)
            slot0 <= slot1;
         if (wr_valid) begin
            if (after_pop == 2'd0)
               slot0 <= wr_data;
            else
               slot1 <= wr_data;
         end
      end
   end
endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains a FIFO read port into a valid/ready stream; m_last built only with FIFO_RD_LAST_EN
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int PKT_LEN = 16
) (
   input  logic             rd_clk,
   input  logic             rd_rst,
   output logic             fifo_rd_en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rd_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last
);
   logic       inflight;
   logic       pop;
   count_t     count;
   logic [2:0] occupancy;

   if (PKT_LEN < 1 || FIFO_RD_LATENCY != 1) begin : g_bad_cfg
      $error("fifo_rd_stream: PKT_LEN must be >= 1 and the FIFO read latency must be 1");
   end

   // Words already owned (buffered or in flight) after this cycle's pop must leave room for one more.
   assign occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_rd_en = ~rd_rst & ~fifo_empty & (occupancy < 3'(SKID_DEPTH));

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst)
         inflight <= 1'b0;
      else
         inflight <= fifo_rd_en;
   end

   fifo_skid_buf #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk      (rd_clk),
      .rst      (rd_rst),
      .wr_valid (inflight),
      .wr_data  (fifo_rd_data),
      .rd_ready (m_ready),
      .rd_valid (m_valid),
      .rd_data  (m_data),
      .pop      (pop),
      .count    (count)
   );

`ifdef FIFO_RD_LAST_EN
   localparam int            BW       = beat_width(PKT_LEN);
   localparam logic [BW-1:0] BEAT_MAX = BW'(PKT_LEN - 1);

   logic [BW-1:0] beat;

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst)
         beat <= '0;
      else if (pop)
         beat <= (beat == BEAT_MAX) ? '0 : beat + BW'(1);
   end

   assign m_last = m_valid & (beat == BEAT_MAX);
`else
   assign m_last = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream with a behavioural one-cycle-latency FIFO
module tb_fifo_rd_stream;
   logic        rd_clk = 1'b0;
   logic        rd_rst = 1'b1;
   logic        fifo_rd_en;
   logic        fifo_empty = 1'b1;
   logic [31:0] fifo_rd_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic        m_last;
   logic        stall = 1'b0;

   logic [31:0] fifo_q[$];
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          beats  = 0;
   int          pops   = 0;
   int          sent;
   int          pops0;
   logic        hold = 1'b0;
   logic [31:0] hold_data;
   logic        hold_last;
   logic [31:0] exp_word;

   always #5 rd_clk = ~rd_clk;

   fifo_rd_stream #(.WIDTH(32), .PKT_LEN(4)) dut (
      .rd_clk       (rd_clk),
      .rd_rst       (rd_rst),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last)
   );

`ifdef FIFO_RD_LAST_EN
   logic        fifo_rd_en1;
   logic        m_valid1;
   logic [31:0] m_data1;
   logic        m_last1;

   fifo_rd_stream #(.WIDTH(32), .PKT_LEN(1)) dut1 (
      .rd_clk       (rd_clk),
      .rd_rst       (rd_rst),
      .fifo_rd_en   (fifo_rd_en1),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .m_valid      (m_valid1),
      .m_ready      (m_ready),
      .m_data       (m_data1),
      .m_last       (m_last1)
   );
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_last(input int idx);
`ifdef FIFO_RD_LAST_EN
      return (idx % 4) == 3;
`else
      return 1'b0;
`endif
   endfunction

   task automatic push(input logic [31:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
   endtask

   // FIFO model: registered read data one cycle after an accepted pop.
   always @(posedge rd_clk) begin
      if (fifo_rd_en) begin
         pops = pops + 1;
         if (fifo_q.size() != 0)
            fifo_rd_data <= fifo_q.pop_front();
      end
   end

   always @(posedge rd_clk) begin
      #2;
      fifo_empty = (fifo_q.size() == 0) || stall;
   end

   always @(negedge rd_clk) begin
      if (!rd_rst) begin
         chk("count_le_2", {31'b0, dut.count <= 2'd2}, 32'd1);
         chk("pop_while_empty", {31'b0, fifo_rd_en & fifo_empty}, 32'd0);
         if (hold) begin
            chk("stall_valid", {31'b0, m_valid}, 32'd1);
            chk("stall_data", m_data, hold_data);
            chk("stall_last", {31'b0, m_last}, {31'b0, hold_last});
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", m_data, 32'hFFFF_FFFF);
            end else begin
               exp_word = exp_q.pop_front();
               chk("beat_data", m_data, exp_word);
               chk("beat_last", {31'b0, m_last}, {31'b0, exp_last(beats)});
               beats++;
            end
         end
`ifdef FIFO_RD_LAST_EN
         if (m_valid1)
            chk("pkt1_last", {31'b0, m_last1}, 32'd1);
`endif
         hold      = m_valid & ~m_ready;
         hold_data = m_data;
         hold_last = m_last;
      end else begin
         hold = 1'b0;
      end
   end

   task automatic do_reset();
      @(negedge rd_clk);
      #2;
      rd_rst  = 1'b1;
      m_ready = 1'b0;
      stall   = 1'b0;
      fifo_q.delete();
      exp_q.delete();
      beats = 0;
      repeat (2) @(posedge rd_clk);
      #1 rd_rst = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge rd_clk);
         #1;
         n++;
      end
      chk("drain_timeout", exp_q.size(), 32'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge rd_clk);
      chk("rst_valid", {31'b0, m_valid}, 32'd0);
      chk("rst_data", m_data, 32'd0);
      chk("rst_last", {31'b0, m_last}, 32'd0);
      chk("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      @(posedge rd_clk);
      #1 rd_rst = 1'b0;

      // 8 words, consumer always ready: 2-cycle latency then gapless beats
      do_reset();
      m_ready = 1'b1;
      @(posedge rd_clk);
      #1;
      for (int i = 0; i < 8; i++) push(32'(i));
      @(negedge rd_clk);
      chk("t2_rd_en_n", {31'b0, fifo_rd_en}, 32'd1);
      chk("t2_valid_n", {31'b0, m_valid}, 32'd0);
      @(negedge rd_clk);
      chk("t2_valid_n1", {31'b0, m_valid}, 32'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge rd_clk);
         chk("t2_gapless", {31'b0, m_valid}, 32'd1);
      end
      @(negedge rd_clk);
      chk("t2_rd_en_done", {31'b0, fifo_rd_en}, 32'd0);
      chk("t2_valid_done", {31'b0, m_valid}, 32'd0);
      drain(20);
      chk("t2_beats", beats, 32'd8);

      // 8 words, consumer stalled for 10 cycles: exactly 2 pops, head held
      do_reset();
      pops0 = pops;
      @(posedge rd_clk);
      #1;
      for (int i = 0; i < 8; i++) push(32'(i));
      repeat (10) @(negedge rd_clk);
      chk("t3_pops", pops - pops0, 32'd2);
      chk("t3_count", {30'b0, dut.count}, 32'd2);
      chk("t3_head", m_data, 32'd0);
      @(posedge rd_clk);
      #1 m_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge rd_clk);
         chk("t3_gapless", {31'b0, m_valid}, 32'd1);
      end
      drain(20);
      chk("t3_beats", beats, 32'd8);

      // Reset mid-stream discards buffered and in-flight words
      do_reset();
      @(posedge rd_clk);
      #1;
      for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
      repeat (3) @(negedge rd_clk);
      chk("t1_pre_valid", {31'b0, m_valid}, 32'd1);
      chk("t1_pre_inflight", {31'b0, dut.inflight}, 32'd1);
      #2;
      rd_rst = 1'b1;
      fifo_q.delete();
      exp_q.delete();
      beats = 0;
      #1;
      chk("t1_valid", {31'b0, m_valid}, 32'd0);
      chk("t1_data", m_data, 32'd0);
      chk("t1_last", {31'b0, m_last}, 32'd0);
      chk("t1_rd_en", {31'b0, fifo_rd_en}, 32'd0);
      chk("t1_count", {30'b0, dut.count}, 32'd0);
      repeat (2) @(posedge rd_clk);
      #1 rd_rst = 1'b0;
      @(posedge rd_clk);
      #1;
      for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
      m_ready = 1'b1;
      drain(20);
      chk("t1_beats", beats, 32'd4);

      // 12 words with alternating stalls: m_last on beats 3, 7, 11 when enabled
      do_reset();
      @(posedge rd_clk);
      #1;
      for (int i = 0; i < 12; i++) push(32'hC0 + 32'(i));
      for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
         @(posedge rd_clk);
         #1 m_ready = c[0] | c[2];
      end
      m_ready = 1'b1;
      drain(20);
      chk("t5_beats", beats, 32'd12);

      // Random ready and FIFO stalls over 1000 words
      do_reset();
      sent = 0;
      for (int c = 0; c < 20000 && (sent < 1000 || exp_q.size() != 0); c++) begin
         @(posedge rd_clk);
         #1;
         m_ready = 1'($urandom_range(0, 1));
         stall   = ($urandom_range(0, 3) == 0);
         if (sent < 1000 && $urandom_range(0, 1) == 1) begin
            push(32'h1000 + 32'(sent));
            sent++;
         end
      end
      stall = 1'b0;
      chk("t4_sent", sent, 32'd1000);
      chk("t4_beats", beats, 32'd1000);
      chk("t4_left", exp_q.size(), 32'd0);

      repeat (3) @(negedge rd_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
